rr_dec139_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-4 decoder channel (active-low enable G_L, selects B/A, active-low outputs Y_L) among 4 requesters.
- Grants one requester at a time and drives the decoder enable and select lines from registered state.
- Exports the decoded active-low grant vector so the lab board can light one grant LED per requester.
- Sits between the requester inputs (switches or FSMs) and the decoder-driven shared resource.

---
 rtl/rr_dec139_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rr_dec139_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_dec139_arbiter.sv
// -----------------------------------------------------------------------------
// rr_dec139_arbiter
//
// Round-robin arbiter that shares one 2-to-4 decoder channel among four
// requesters. The decoder enable (G_L) and selects (B, A) come straight from
// registered state, and the decoded active-low grant vector (Y_L) is exported
// so each requester can light its own grant LED.
//
// Ports:
//   CLK      in   1  system clock, rising edge
//   RESET    in   1  synchronous, active-high reset
//   REQ      in   4  request lines, active-high, REQ[i] = requester i
//   G_L      out  1  decoder enable, active-low, 0 only while a grant is active
//   B, A     out  1  decoder selects, granted index bit 1 / bit 0
//   Y_L      out  4  decoded grant, active-low, all ones when G_L=1
//   BUSY     out  1  high while a grant is active
//   TIMEOUT  out  1  one-cycle pulse in the GAP cycle after a forced revoke
//
// Configuration macro:
//   ARB_TIMEOUT_EN  builds the hold counter and forcibly revokes a grant held
//                   for MAX_HOLD cycles. Undefined: TIMEOUT is tied to 0 and a
//                   grant is held for as long as its owner requests.
// -----------------------------------------------------------------------------
module rr_dec139_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQ,
    output logic       G_L,
    output logic       B,
    output logic       A,
    output logic [3:0] Y_L,
    output logic       BUSY,
    output logic       TIMEOUT
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > (2 ** CNT_W) - 1)) begin : g_bad_cfg
        $error("rr_dec139_arbiter: MAX_HOLD out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] sel, sel_nxt;      // drives {B,A}; only moves on entry to GRANT
    logic [1:0] last, last_nxt;    // most recently granted index
    logic [2:0] pick;              // {found, index} from the round-robin search

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             timeout_q, timeout_nxt;
`endif

    // Search starts just after the last winner and visits it last, so a
    // requester that was just served has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [1:0] last_idx,
                                           input logic [3:0] req);
        logic [2:0] found;
        logic [1:0] cand;
        found = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = last_idx + 2'(k);
            if (!found[2] && req[cand]) begin
                found = {1'b1, cand};
            end
        end
        return found;
    endfunction

    assign pick = rr_pick(last, REQ);

    // State register
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (RESET) begin
            state     <= IDLE;
            sel       <= 2'b00;
            last      <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            last      <= last_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt    = state;
        sel_nxt      = sel;
        last_nxt     = last;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
`endif
        case (state)
            IDLE, GAP: begin
                if (pick[2]) begin
                    state_nxt    = GRANT;
                    sel_nxt      = pick[1:0];
                    last_nxt     = pick[1:0];
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt = '0;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!REQ[sel]) begin
                    // Voluntary release wins over a simultaneous limit hit.
                    state_nxt = GAP;
`ifdef ARB_TIMEOUT_EN
                // hold_cnt counts completed GRANT cycles minus one, so this
                // edge ends the MAX_HOLD-th cycle of the grant.
                end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_nxt   = GAP;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs, decoded only from registers
    always_comb begin
        G_L    = (state != GRANT);
        BUSY   = (state == GRANT);
        B      = sel[1];
        A      = sel[0];
        Y_L    = 4'hF;
        if (state == GRANT) begin
            Y_L[sel] = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        TIMEOUT = timeout_q;
`else
        TIMEOUT = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_dec139_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_dec139_arbiter
//
// Self-checking bench for rr_dec139_arbiter. Directed scenarios compare the
// packed output vector {G_L, B, A, Y_L, BUSY, TIMEOUT} against constants; a
// randomized run compares it against a behavioural model of the arbiter's
// rules. Define ARB_TIMEOUT_EN for both bench and RTL to cover the hold limit.
// -----------------------------------------------------------------------------
module tb_rr_dec139_arbiter;

    localparam int MAX_HOLD = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] REQ;
    logic       G_L, B, A, BUSY, TIMEOUT;
    logic [3:0] Y_L;

    int checks = 0;
    int passed = 0;

    rr_dec139_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ     (REQ),
        .G_L     (G_L),
        .B       (B),
        .A       (A),
        .Y_L     (Y_L),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: who owns the channel, for how long, whose turn is last
    bit         m_busy;
    logic [1:0] m_sel;
    int         m_last;
    int         m_held;
    bit         m_to;

    task automatic model_edge(input logic rst, input logic [3:0] r);
        bit done;
        int idx;
        if (rst) begin
            m_busy = 0; m_sel = 2'b00; m_last = 3; m_held = 0; m_to = 0;
        end else if (m_busy) begin
            m_to = 0;
            if (r[m_sel] == 1'b0) begin
                m_busy = 0;
`ifdef ARB_TIMEOUT_EN
            end else if (m_held == MAX_HOLD) begin
                m_busy = 0;
                m_to   = 1;
`endif
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            m_to = 0;
            done = 0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (!done && r[idx]) begin
                    done   = 1;
                    m_busy = 1;
                    m_sel  = 2'(idx);
                    m_last = idx;
                    m_held = 1;
                end
            end
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] y;
        y = m_busy ? ~(4'b0001 << m_sel) : 4'b1111;
        return {~m_busy, m_sel, y, m_busy, m_to};
    endfunction

    function automatic logic [8:0] observed();
        return {G_L, B, A, Y_L, BUSY, TIMEOUT};
    endfunction

    function automatic logic [8:0] granted(input int o);
        logic [1:0] s;
        s = 2'(o);
        return {1'b0, s, ~(4'b0001 << s), 1'b1, 1'b0};
    endfunction

    function automatic logic [8:0] released(input int o, input bit to);
        logic [1:0] s;
        s = 2'(o);
        return {1'b1, s, 4'b1111, 1'b0, to};
    endfunction

    // Apply inputs for one edge, then sample #1 after it
    task automatic step(input logic rst, input logic [3:0] r);
        RESET = rst;
        REQ   = r;
        @(posedge CLK);
        #1;
        model_edge(rst, r);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000);
            checks++;
            if (observed() !== 9'b1_00_1111_0_0)
                $display("FAIL reset[%0d]: got %b want %b", i, observed(), 9'b1_00_1111_0_0);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [3:0] reqs [5];
        logic [8:0] exps [5];
        reqs = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        exps = '{9'b0_10_1011_1_0, 9'b0_10_1011_1_0, 9'b0_10_1011_1_0,
                 9'b1_10_1111_0_0, 9'b1_10_1111_0_0};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, reqs[i]);
            checks++;
            if (observed() !== exps[i])
                $display("FAIL single[%0d]: got %b want %b", i, observed(), exps[i]);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        int o;
        step(1'b1, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            o = g % 4;
            for (int c = 0; c < 2; c++) begin
                step(1'b0, 4'b1111);
                checks++;
                if (observed() !== granted(o))
                    $display("FAIL rr_grant[%0d.%0d]: got %b want %b", g, c, observed(), granted(o));
                else passed++;
            end
            step(1'b0, 4'b1111 & ~(4'b0001 << o));
            checks++;
            if (observed() !== released(o, 1'b0))
                $display("FAIL rr_gap[%0d]: got %b want %b", g, observed(), released(o, 1'b0));
            else passed++;
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_hold_limit();
        // {req, expected} per edge: 0011 case then 0001 case
        logic [3:0] reqs [14];
        logic [8:0] exps [14];
        reqs = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0001, 4'b0001};
        exps = '{granted(0), granted(0), granted(0), granted(0),
                 released(0, 1'b1), granted(1),
                 released(1, 1'b0), granted(0), granted(0), granted(0),
                 granted(0), released(0, 1'b1), granted(0), granted(0)};
        step(1'b1, 4'b0000);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, reqs[i]);
            checks++;
            if (observed() !== exps[i])
                $display("FAIL hold_limit[%0d]: got %b want %b", i, observed(), exps[i]);
            else passed++;
        end
    endtask
`else
    task automatic test_hold_limit();
        step(1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0011);
            checks++;
            if (observed() !== granted(0))
                $display("FAIL hold_forever[%0d]: got %b want %b", i, observed(), granted(0));
            else passed++;
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        logic [3:0] reqs [4];
        logic       rsts [4];
        logic [8:0] exps [4];
        reqs = '{4'b0100, 4'b0100, 4'b1001, 4'b1001};
        rsts = '{1'b0, 1'b0, 1'b1, 1'b0};
        exps = '{granted(2), granted(2), 9'b1_00_1111_0_0, granted(0)};
        step(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(rsts[i], reqs[i]);
            checks++;
            if (observed() !== exps[i])
                $display("FAIL reset_mid[%0d]: got %b want %b", i, observed(), exps[i]);
            else passed++;
        end
    endtask

    task automatic test_toggle_others();
        step(1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b0010 | ((i % 2) ? 4'b1101 : 4'b0000));
            checks++;
            if (observed() !== granted(1))
                $display("FAIL toggle[%0d]: got %b want %b", i, observed(), granted(1));
            else passed++;
        end
    endtask

    task automatic test_random();
        logic       rst;
        logic [3:0] r;
        step(1'b1, 4'b0000);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            r   = 4'($urandom);
            if (m_busy && ($urandom_range(0, 99) < 85)) r[m_sel] = 1'b1;
            step(rst, r);
            checks++;
            if (observed() !== model_out())
                $display("FAIL random[%0d] req=%b rst=%b: got %b want %b",
                         i, r, rst, observed(), model_out());
            else passed++;
        end
    endtask

    initial begin
        RESET = 1'b1;
        REQ   = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_reset_mid_grant();
        test_toggle_others();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
